// File: rtl/branch_pkg.sv
// Shared opcodes, flag bit positions and the decoded branch kind for pc_branch_unit.
package branch_pkg;

  localparam logic [3:0] OP_JMP  = 4'b1001;
  localparam logic [3:0] OP_BRZ  = 4'b1010;
  localparam logic [3:0] OP_BRNZ = 4'b1011;
  localparam logic [3:0] OP_BRNS = 4'b1100;
  localparam logic [3:0] OP_CALL = 4'b1101;
  localparam logic [3:0] OP_RET  = 4'b1110;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;

  typedef enum logic [1:0] {SEQ, TAKEN, CALL, RET} branch_kind;

  // Conditions use the stored flags only; unknown opcodes fall through as sequential.
  function automatic branch_kind decode_kind(input logic en, input logic [3:0] op,
                                             input logic z, input logic s);
    branch_kind k;
    k = SEQ;
    if (en) begin
      case (op)
        OP_JMP:  k = TAKEN;
        OP_BRZ:  k = z ? TAKEN : SEQ;
        OP_BRNZ: k = z ? SEQ : TAKEN;
        OP_BRNS: k = s ? SEQ : TAKEN;
        OP_CALL: k = CALL;
        OP_RET:  k = RET;
        default: k = SEQ;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry, count saturates.
module return_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic             full;
  logic             empty;

  // ptr names the next free slot; when full it also names the oldest entry.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign top   = mem[ptr - PTR_W'(1)];
  assign ovf   = push && full;
  assign unf   = pop && empty;

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with branch resolution, latched flags and a CALL/RET return stack.
module pc_branch_unit
  import branch_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int FLAG_W    = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         branch_enable,
  input  logic [3:0]                   branch_type,
  input  logic [PC_W-1:0]              branch_offset,
  input  logic [FLAG_W-1:0]            flags_in,
  input  logic                         flags_we,
  output logic [PC_W-1:0]              pc,
  output logic                         flush,
  output logic                         ras_ovf,
  output logic                         ras_unf,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  logic [FLAG_W-1:0] flags_q;
  branch_kind        kind;
  logic [PC_W-1:0]   pc_seq;
  logic [PC_W-1:0]   pc_tgt;
  logic [PC_W-1:0]   ras_top;
  logic              push;
  logic              pop;
  logic              rs_ovf;
  logic              rs_unf;
  logic              unused_flags;

  // Upper flag bits are architecturally stored but never steer a branch.
  assign unused_flags = ^flags_q;

  assign kind   = stall ? SEQ
                        : decode_kind(branch_enable, branch_type, flags_q[FLAG_Z], flags_q[FLAG_S]);
  assign pc_seq = pc + PC_W'(1);
  assign pc_tgt = pc + branch_offset;
  assign push   = (kind == CALL);
  assign pop    = (kind == RET);

  return_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_seq),
    .top   (ras_top),
    .count (ras_count),
    .ovf   (rs_ovf),
    .unf   (rs_unf)
  );

  // Flag writes are independent of stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        flags_q <= '0;
    else if (flags_we) flags_q <= flags_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      flush   <= 1'b0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      flush   <= 1'b0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
      if (!stall) begin
        case (kind)
          SEQ: pc <= pc_seq;
          TAKEN: begin
            pc    <= pc_tgt;
            flush <= 1'b1;
          end
          CALL: begin
            pc      <= pc_tgt;
            flush   <= 1'b1;
            ras_ovf <= rs_ovf;
          end
          RET: begin
            if (rs_unf) begin
              pc      <= pc_seq;
              ras_unf <= 1'b1;
            end else begin
              pc    <= ras_top;
              flush <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: a behavioural model pushes expected state per cycle.
module tb_pc_branch_unit;

  localparam logic [3:0] T_JMP  = 4'b1001;
  localparam logic [3:0] T_BRZ  = 4'b1010;
  localparam logic [3:0] T_BRNZ = 4'b1011;
  localparam logic [3:0] T_BRNS = 4'b1100;
  localparam logic [3:0] T_CALL = 4'b1101;
  localparam logic [3:0] T_RET  = 4'b1110;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_enable = 1'b0;
  logic [3:0]  branch_type = '0;
  logic [15:0] branch_offset = '0;
  logic [3:0]  flags_in = '0;
  logic        flags_we = 1'b0;
  logic [15:0] pc;
  logic        flush;
  logic        ras_ovf;
  logic        ras_unf;
  logic [2:0]  ras_count;

  pc_branch_unit #(.PC_W(16), .FLAG_W(4), .RAS_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_enable (branch_enable),
    .branch_type   (branch_type),
    .branch_offset (branch_offset),
    .flags_in      (flags_in),
    .flags_we      (flags_we),
    .pc            (pc),
    .flush         (flush),
    .ras_ovf       (ras_ovf),
    .ras_unf       (ras_unf),
    .ras_count     (ras_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic        flush;
    logic        ovf;
    logic        unf;
    logic [2:0]  cnt;
  } obs_t;

  typedef struct {
    logic        en;
    logic [3:0]  ty;
    logic [15:0] off;
    logic [3:0]  fin;
    logic        fwe;
    logic        st;
    logic        ab;   // off is an absolute target; converted to a displacement at drive time
  } stim_t;

  obs_t        sb[$];
  logic [15:0] m_stack[$];
  logic [15:0] m_pc = '0;
  logic [3:0]  m_flags = '0;
  int          n_checks = 0;
  int          n_fails = 0;

  function automatic stim_t mk(input logic en, input logic [3:0] ty, input logic [15:0] off,
                               input logic [3:0] fin, input logic fwe, input logic st,
                               input logic ab);
    stim_t s;
    s.en = en; s.ty = ty; s.off = off; s.fin = fin; s.fwe = fwe; s.st = st; s.ab = ab;
    return s;
  endfunction

  function automatic obs_t observe();
    return {pc, flush, ras_ovf, ras_unf, ras_count};
  endfunction

  // Drive one cycle of stimulus, advance the model, queue its expectation, then step past the edge.
  task automatic drive(input stim_t s);
    obs_t        e;
    logic [15:0] off;
    logic [15:0] npc;
    logic        taken;
    off = s.ab ? (s.off - m_pc) : s.off;
    branch_enable = s.en;
    branch_type   = s.ty;
    branch_offset = off;
    flags_in      = s.fin;
    flags_we      = s.fwe;
    stall         = s.st;
    e = '0;
    if (!s.st) begin
      taken = 1'b0;
      npc   = m_pc + 16'd1;
      if (s.en) begin
        case (s.ty)
          T_JMP:  taken = 1'b1;
          T_BRZ:  taken = m_flags[0];
          T_BRNZ: taken = !m_flags[0];
          T_BRNS: taken = !m_flags[1];
          T_CALL: begin
            m_stack.push_back(m_pc + 16'd1);
            if (m_stack.size() > DEPTH) begin
              void'(m_stack.pop_front());
              e.ovf = 1'b1;
            end
            taken = 1'b1;
          end
          T_RET: begin
            if (m_stack.size() > 0) begin
              npc     = m_stack.pop_back();
              e.flush = 1'b1;
            end else begin
              e.unf = 1'b1;
            end
          end
          default: taken = 1'b0;
        endcase
      end
      if (taken) begin
        npc     = m_pc + off;
        e.flush = 1'b1;
      end
      m_pc = npc;
    end
    if (s.fwe) m_flags = s.fin;
    e.pc  = m_pc;
    e.cnt = 3'(m_stack.size());
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t tab[$];
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (observe() !== obs_t'(0)) begin
      n_fails++;
      $display("FAIL reset_values: got %h, expected 0 (pc,flush,ovf,unf,count)", observe());
    end
    rst_n = 1'b1;
    tab = '{mk(0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0)};
    foreach (tab[i]) begin
      obs_t ex, ob;
      drive(tab[i]);
      ex = sb.pop_front(); ob = observe(); n_checks++;
      if (ob !== ex) begin
        n_fails++;
        $display("FAIL seq_after_reset[%0d]: got pc=%h fl/ov/un=%b%b%b cnt=%0d, expected pc=%h fl/ov/un=%b%b%b cnt=%0d",
                 i, ob.pc, ob.flush, ob.ovf, ob.unf, ob.cnt, ex.pc, ex.flush, ex.ovf, ex.unf, ex.cnt);
      end
    end
    n_checks++;
    if (pc !== 16'd3) begin
      n_fails++;
      $display("FAIL seq_pc3: got pc=%h, expected 0003", pc);
    end
  endtask

  task automatic test_flags_branch();
    stim_t tab[$];
    tab = '{mk(0,0,0,4'h1,1,0,0),                 // latch Z=1, pc 3->4
            mk(0,0,0,0,0,0,0),                    // pc 5
            mk(1,T_BRZ,16'hFFFE,0,0,0,0),         // taken -> 3
            mk(1,T_BRNZ,16'h0040,0,0,0,0)};       // not taken -> 4
    foreach (tab[i]) begin
      obs_t ex, ob;
      drive(tab[i]);
      ex = sb.pop_front(); ob = observe(); n_checks++;
      if (ob !== ex) begin
        n_fails++;
        $display("FAIL flags_branch[%0d]: got pc=%h fl/ov/un=%b%b%b cnt=%0d, expected pc=%h fl/ov/un=%b%b%b cnt=%0d",
                 i, ob.pc, ob.flush, ob.ovf, ob.unf, ob.cnt, ex.pc, ex.flush, ex.ovf, ex.unf, ex.cnt);
      end
    end
    n_checks++;
    if (pc !== 16'd4 || flush !== 1'b0) begin
      n_fails++;
      $display("FAIL brnz_not_taken: got pc=%h flush=%b, expected pc=0004 flush=0", pc, flush);
    end
  endtask

  task automatic test_same_cycle_flags();
    stim_t tab[$];
    tab = '{mk(0,0,0,4'h0,1,0,0),                 // Z=0
            mk(1,T_BRZ,16'h0010,4'h1,1,0,0),      // sees old Z=0, not taken
            mk(1,T_BRZ,16'h0010,0,0,0,0),         // taken now
            mk(0,0,0,4'h2,1,0,0),                 // S=1
            mk(1,T_BRNS,16'h0008,4'h0,1,0,0),     // sees S=1, not taken
            mk(1,T_BRNS,16'h0008,0,0,0,0),        // S=0, taken
            mk(1,4'b0011,16'h0050,0,0,0,0),       // unknown opcode
            mk(0,T_JMP,16'h0050,0,0,0,0)};        // enable low
    foreach (tab[i]) begin
      obs_t ex, ob;
      drive(tab[i]);
      ex = sb.pop_front(); ob = observe(); n_checks++;
      if (ob !== ex) begin
        n_fails++;
        $display("FAIL same_cycle_flags[%0d]: got pc=%h fl/ov/un=%b%b%b cnt=%0d, expected pc=%h fl/ov/un=%b%b%b cnt=%0d",
                 i, ob.pc, ob.flush, ob.ovf, ob.unf, ob.cnt, ex.pc, ex.flush, ex.ovf, ex.unf, ex.cnt);
      end
    end
  endtask

  task automatic test_call_ret();
    stim_t tab[$];
    tab = '{mk(1,T_JMP,16'h0010,0,0,0,1),         // go to 0x0010
            mk(1,T_CALL,16'h0020,0,0,0,0),        // -> 0x0030, count 1
            mk(1,T_RET,0,0,0,0,0),                // -> 0x0011
            mk(1,T_RET,0,0,0,0,0),                // underflow -> 0x0012
            mk(0,T_CALL,16'h0040,0,0,0,0)};       // enable low: no push, 0x0013
    foreach (tab[i]) begin
      obs_t ex, ob;
      drive(tab[i]);
      ex = sb.pop_front(); ob = observe(); n_checks++;
      if (ob !== ex) begin
        n_fails++;
        $display("FAIL call_ret[%0d]: got pc=%h fl/ov/un=%b%b%b cnt=%0d, expected pc=%h fl/ov/un=%b%b%b cnt=%0d",
                 i, ob.pc, ob.flush, ob.ovf, ob.unf, ob.cnt, ex.pc, ex.flush, ex.ovf, ex.unf, ex.cnt);
      end
    end
    n_checks++;
    if (pc !== 16'h0013 || ras_count !== 3'd0) begin
      n_fails++;
      $display("FAIL call_ret_end: got pc=%h count=%0d, expected pc=0013 count=0", pc, ras_count);
    end
  endtask

  task automatic test_overflow();
    stim_t tab[$];
    tab.push_back(mk(1,T_JMP,16'h0100,0,0,0,1));
    repeat (5) tab.push_back(mk(1,T_CALL,16'h0010,0,0,0,0));
    repeat (5) tab.push_back(mk(1,T_RET,0,0,0,0,0));
    foreach (tab[i]) begin
      obs_t ex, ob;
      drive(tab[i]);
      ex = sb.pop_front(); ob = observe(); n_checks++;
      if (ob !== ex) begin
        n_fails++;
        $display("FAIL overflow[%0d]: got pc=%h fl/ov/un=%b%b%b cnt=%0d, expected pc=%h fl/ov/un=%b%b%b cnt=%0d",
                 i, ob.pc, ob.flush, ob.ovf, ob.unf, ob.cnt, ex.pc, ex.flush, ex.ovf, ex.unf, ex.cnt);
      end
    end
    n_checks++;
    if (pc !== 16'h0112 || ras_unf !== 1'b1) begin
      n_fails++;
      $display("FAIL overflow_end: got pc=%h unf=%b, expected pc=0112 unf=1", pc, ras_unf);
    end
  endtask

  task automatic test_stall_wrap_reset();
    stim_t tab[$];
    tab = '{mk(1,T_JMP,16'h0200,0,0,0,1),
            mk(1,T_JMP,16'h0080,0,0,1,0),         // stalled: hold
            mk(1,T_JMP,16'h0080,4'h0,1,1,0),      // stalled, flags still written (Z=0)
            mk(1,T_CALL,16'h0080,0,0,1,0),        // stalled CALL: no push
            mk(1,T_BRNZ,16'h0004,0,0,0,0),        // taken on Z=0
            mk(1,T_JMP,16'hFFFF,0,0,0,1),
            mk(1,T_JMP,16'h0002,0,0,0,0)};        // wraps to 0x0001
    foreach (tab[i]) begin
      obs_t ex, ob;
      drive(tab[i]);
      ex = sb.pop_front(); ob = observe(); n_checks++;
      if (ob !== ex) begin
        n_fails++;
        $display("FAIL stall_wrap[%0d]: got pc=%h fl/ov/un=%b%b%b cnt=%0d, expected pc=%h fl/ov/un=%b%b%b cnt=%0d",
                 i, ob.pc, ob.flush, ob.ovf, ob.unf, ob.cnt, ex.pc, ex.flush, ex.ovf, ex.unf, ex.cnt);
      end
    end
    n_checks++;
    if (pc !== 16'h0001 || flush !== 1'b1) begin
      n_fails++;
      $display("FAIL jmp_wrap: got pc=%h flush=%b, expected pc=0001 flush=1", pc, flush);
    end
    drive(mk(1,T_CALL,16'h0010,4'h1,1,0,0));     // count 1, Z=1 before reset
    void'(sb.pop_front());
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pc !== 16'h0000 || ras_count !== 3'd0 || flush !== 1'b0) begin
      n_fails++;
      $display("FAIL async_reset: got pc=%h count=%0d flush=%b, expected pc=0000 count=0 flush=0",
               pc, ras_count, flush);
    end
    m_pc = '0; m_flags = '0; m_stack.delete();
    branch_enable = 1'b0; flags_we = 1'b0; stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tab = '{mk(1,T_BRZ,16'h0040,0,0,0,0),         // flags cleared: not taken
            mk(1,T_RET,0,0,0,0,0)};               // stack cleared: underflow
    foreach (tab[i]) begin
      obs_t ex, ob;
      drive(tab[i]);
      ex = sb.pop_front(); ob = observe(); n_checks++;
      if (ob !== ex) begin
        n_fails++;
        $display("FAIL after_reset[%0d]: got pc=%h fl/ov/un=%b%b%b cnt=%0d, expected pc=%h fl/ov/un=%b%b%b cnt=%0d",
                 i, ob.pc, ob.flush, ob.ovf, ob.unf, ob.cnt, ex.pc, ex.flush, ex.ovf, ex.unf, ex.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t tab[$];
    tab = '{mk(1,T_JMP,16'h0004,0,0,0,0), mk(1,T_JMP,16'h0004,0,0,0,0),
            mk(1,T_CALL,16'h0100,0,0,0,0), mk(1,T_RET,0,0,0,0,0)};
    foreach (tab[i]) begin
      obs_t ex, ob;
      drive(tab[i]);
      ex = sb.pop_front(); ob = observe(); n_checks++;
      if (ob !== ex || flush !== 1'b1) begin
        n_fails++;
        $display("FAIL back_to_back[%0d]: got pc=%h fl/ov/un=%b%b%b cnt=%0d, expected pc=%h fl/ov/un=%b%b%b cnt=%0d",
                 i, ob.pc, ob.flush, ob.ovf, ob.unf, ob.cnt, ex.pc, ex.flush, ex.ovf, ex.unf, ex.cnt);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      obs_t  ex, ob;
      stim_t s;
      s = mk($urandom_range(0, 7) != 0, 4'($urandom_range(8, 15)), 16'($urandom),
             4'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, 1'b0);
      drive(s);
      ex = sb.pop_front(); ob = observe(); n_checks++;
      if (ob !== ex) begin
        n_fails++;
        $display("FAIL random[%0d]: got pc=%h fl/ov/un=%b%b%b cnt=%0d, expected pc=%h fl/ov/un=%b%b%b cnt=%0d",
                 i, ob.pc, ob.flush, ob.ovf, ob.unf, ob.cnt, ex.pc, ex.flush, ex.ovf, ex.unf, ex.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flags_branch();
    test_same_cycle_flags();
    test_call_ret();
    test_overflow();
    test_stall_wrap_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Registered program-counter and branch-resolution block for the tiny core, parametrised in PC width, flag width and return-stack depth. Owns the PC register, a latched condition-flag register and a circular return-address stack, so the core gains CALL/RET and a stall input. Sits between decode, which supplies the branch type, offset and enable, and instruction fetch, which consumes `pc` and `flush`.

## Interface
- `PC_W`, 16: width of the PC, branch offset and return addresses.
- `FLAG_W`, 4: width of the flag register. Bit 0 is zero, bit 1 is sign/overflow, higher bits are stored but not used; `FLAG_W` ≥ 2.
- `RAS_DEPTH`, 4: number of return-stack entries, power of two, ≥ 2.
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `stall` in 1: hold the PC and return stack this cycle.
- `branch_enable` in 1: the instruction this cycle is a control-flow instruction.
- `branch_type` in 4: control-flow opcode, listed under Operation.
- `branch_offset` in `PC_W`: two's-complement displacement.
- `flags_in` in `FLAG_W`: new flag value from the ALU.
- `flags_we` in 1: load `flags_in` into the flag register.
- `pc` out `PC_W`: current PC, registered.
- `flush` out 1: registered pulse marking that `pc` was just redirected.
- `ras_ovf` out 1: registered pulse when a CALL overwrites the oldest stack entry.
- `ras_unf` out 1: registered pulse when a RET finds the stack empty.
- `ras_count` out `$clog2(RAS_DEPTH)+1`: number of valid stack entries.

## Operation
- Opcodes: JMP `4'b1001` (always taken), BRZ `4'b1010` (taken if Z), BRNZ `4'b1011` (taken if !Z), BRNS `4'b1100` (taken if !flags[1]), CALL `4'b1101`, RET `4'b1110`. All other codes are not taken.
- Branch conditions read the stored flag register, never `flags_in`. If `flags_we` and a branch occur in the same cycle, the branch sees the old flags and the new flags land at the edge.
- `flags_we` is honoured even while `stall` is high.
- Target is `pc + branch_offset`, truncated modulo 2^`PC_W`. Wrap-around in either direction is legal.
- Sequential next PC is `pc + 1`. 0xFFFF+1 wraps to 0x0000 at `PC_W`=16.
- CALL pushes `pc + 1` and jumps to the target.
  - Stack full: the new entry overwrites the oldest, `ras_count` stays at `RAS_DEPTH`, `ras_ovf` pulses.
- RET pops the top entry and jumps to it.
  - Stack empty: PC goes to `pc + 1`, no flush, `ras_unf` pulses, `ras_count` stays 0.
- `branch_enable` low: PC goes to `pc + 1` and the stack is untouched, whatever `branch_type` says.
- `stall` high: `pc`, the stack and `ras_count` hold; `flush`, `ras_ovf` and `ras_unf` are 0 the next cycle; the branch inputs are ignored.
- Taken redirect means a taken branch/JMP, a CALL, or a RET on a non-empty stack.

## Timing
- Reset values: `pc`=0, flags=0, `ras_count`=0, stack pointer=0, `flush`=0, `ras_ovf`=0, `ras_unf`=0. Stack contents are don't-care.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first update is on the first rising edge after `rst_n` deasserts.
- Latency is one cycle: inputs sampled at edge N give the new `pc` after edge N.
- `flush` is high for exactly the cycle in which `pc` holds a redirect target. Back-to-back taken branches give `flush` high on consecutive cycles.
- `ras_count` updates at the same edge as `pc`.

## Structure
- Package `branch_pkg` holds the opcode localparams, the flag bit indices (`FLAG_Z`=0, `FLAG_S`=1) and a `branch_kind` enum: SEQ, TAKEN, CALL, RET.
- Sub-module `return_stack`:
  - Parameters: `W`, `DEPTH`.
  - Ports: `clk`, `rst_n`, `push`, `pop`, `din`, `top`, `count`, `ovf`, `unf`.
  - Circular buffer with a wrapping pointer and a saturating count.
  - `push` and `pop` are never asserted together by the parent.
- Top level: a combinational decode into `branch_kind`, plus the PC, flag and pulse registers.

## Test plan
- Reset then 3 cycles, no branches: `pc` = 0, 1, 2, 3; `flush`=0 throughout.
- Flags latched Z=1, then BRZ with offset 0xFFFE at `pc`=5: `pc`=3 next cycle with `flush`=1. Then BRNZ: not taken, `pc`=4.
- Same-cycle `flags_we` (Z 0→1) and BRZ: branch not taken. The following BRZ is taken.
- CALL at `pc`=0x0010 with offset 0x0020 → `pc`=0x0030, `ras_count`=1. RET → `pc`=0x0011, `ras_count`=0. A second RET → `pc`=0x0012 and `ras_unf`=1 for one cycle.
- 5 CALLs with `RAS_DEPTH`=4: the 5th pulses `ras_ovf`. Four RETs return to the last four pushed addresses in LIFO order; the 5th RET underflows.
- JMP with `stall`=1 held for 2 cycles: `pc` holds. Then JMP at `pc`=0xFFFF with offset 0x0002 and no stall → `pc`=0x0001, `flush`=1. Assert `rst_n`=0 mid-cycle → `pc`=0 immediately.
